uart_bus_master: RTL
====================

// Module: uart_bus_master
// PURPOSE
//  Debug and loader initiator for the CPU/Device memory bus, driven by a byte stream from the UART.
//  Decodes host command frames, requests the bus from the CPU, and issues one 32-bit read or write.
//  Returns a response frame over the same byte stream.
//  Sits beside the CPU in the top level; the top level muxes its bus outputs in place of the CPU's while hold_ack=1.
// PARAMETERS
//  TIMEOUT_CYCLES  27000000  max clk cycles between bytes inside a frame before the frame is aborted
//  TO_W            25        width of the inter-byte timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  rx_valid     in   1   rx_data valid; one-cycle pulse per received byte
//  rx_data      in   8   received byte
//  tx_valid     out  1   tx_data valid; held until tx_ready
//  tx_data      out  8   byte to transmit
//  tx_ready     in   1   transmitter accepts tx_data this cycle when tx_valid=1
//  hold_req     out  1   request bus ownership from CPU
//  hold_ack     in   1   CPU stalled, bus granted
//  bus_read     out  1   read strobe, single cycle
//  bus_write    out  1   write strobe, single cycle
//  bus_address  out  32  byte address (word aligned)
//  bus_wdata    out  32  write data
//  bus_rdata    in   32  read data; combinational, valid in the same cycle as bus_read
// BEHAVIOUR
//  Reset: state=IDLE; tx_valid, hold_req, bus_read, bus_write=0; bus_address, bus_wdata, tx_data=0.
//  Frames (multi-byte fields MSB first):
//   'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> response 'K'(0x4B)
//   'R'(0x52) A3 A2 A1 A0             -> response D3 D2 D1 D0
//   any other first byte              -> response '?'(0x3F); no bus access
//   address[1:0]!=0 (checked after A0) -> response 'E'(0x45); no bus access; W data bytes still consumed
//  FSM:
//   IDLE: on rx_valid, latch cmd. W/R -> ADDR (cnt=0). Other -> RESP with the single byte '?'.
//   ADDR: shift in 4 bytes; after the 4th: misaligned -> (W ? DATA : RESP 'E'); aligned -> (W ? DATA : REQ).
//   DATA: shift in 4 bytes; after the 4th -> misaligned ? RESP 'E' : REQ.
//   REQ: hold_req=1; the first cycle with hold_ack=1 -> BUS.
//   BUS: exactly one cycle; bus_read or bus_write=1; hold_req stays 1.
//        Read latches bus_rdata at the end of this cycle. -> RESP.
//   RESP: hold_req=0 on entry; present bytes on tx_data with tx_valid=1; advance on tx_valid&&tx_ready.
//         Returns to IDLE after the last byte (1 byte for K/?/E, 4 bytes for read data).
//  Timeout: in ADDR/DATA a free counter increments each cycle without rx_valid and clears on rx_valid.
//   Reaching TIMEOUT_CYCLES -> IDLE silently; no response, no bus access.
//  rx_valid in REQ/BUS/RESP is ignored and the byte dropped (host must wait for the response).
//  bus_address/bus_wdata are only meaningful when a strobe is high.
//   They hold the last frame's values otherwise; both strobes are never high together.
//  Latency: last frame byte -> hold_req is 1 cycle; hold_ack -> strobe is 1 cycle; strobe -> tx_valid is 1 cycle.
//  hold_ack dropping while in REQ: keep waiting. hold_ack is ignored in every other state.
//  Reset mid-frame or mid-response: immediate return to IDLE with all outputs at reset values.
//   A partial tx byte is abandoned.
// TESTING
//  1 W 00 00 10 04 DE AD BE EF, hold_ack=1 after 3 cycles -> one bus_write, addr 0x00001004, wdata 0xDEADBEEF; tx 0x4B.
//  2 R 00 00 10 04, bus_rdata=0x12345678 -> one bus_read; tx 12 34 56 78; tx_ready stalled 5 cycles mid-stream holds the byte.
//  3 Byte 0x41 -> tx 0x3F, no strobe, no hold_req; then a valid R frame succeeds.
//  4 W 00 00 00 02 + 4 data bytes -> tx 0x45; no hold_req, no strobe.
//  5 R 00 00 then a gap of TIMEOUT_CYCLES (set to 100) -> IDLE, no tx; next full frame is decoded correctly.
//  6 reset asserted during BUS/RESP -> all outputs 0 next cycle; the following W frame completes normally.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: decodes W/R host frames, borrows the CPU bus via
// hold_req/hold_ack, performs one 32-bit access and streams back a response.
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 27000000,
    parameter int TO_W           = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        hold_req,
    input  logic        hold_ack,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] CMD_W  = 8'h57;
    localparam logic [7:0] CMD_R  = 8'h52;
    localparam logic [7:0] RSP_K  = 8'h4B;
    localparam logic [7:0] RSP_Q  = 8'h3F;
    localparam logic [7:0] RSP_E  = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_BUS,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [1:0]      cnt;
    logic            is_write;
    logic            misaligned;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     resp_q;
    logic [2:0]      resp_left;
    logic [TO_W-1:0] to_cnt;

    logic timeout;
    logic last_byte;
    logic tx_fire;

    assign timeout   = !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign last_byte = rx_valid && (cnt == 2'd3);
    assign tx_fire   = tx_valid && tx_ready;

    // Handshake: a tx byte moves only in a cycle where tx_valid && tx_ready;
    // tx_valid/tx_data stay stable until then. rx has no back-pressure.
    assign tx_valid    = (state == S_RESP);
    assign tx_data     = tx_valid ? resp_q[31:24] : 8'h00;
    assign hold_req    = (state == S_REQ) || (state == S_BUS);
    assign bus_write   = (state == S_BUS) && is_write;
    assign bus_read    = (state == S_BUS) && !is_write;
    assign bus_address = addr_q;
    assign bus_wdata   = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        state_nx = S_ADDR;
                    end else begin
                        state_nx = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (timeout) begin
                    state_nx = S_IDLE;
                end else if (last_byte) begin
                    if (is_write) begin
                        state_nx = S_DATA;
                    end else if (rx_data[1:0] != 2'b00) begin
                        state_nx = S_RESP;
                    end else begin
                        state_nx = S_REQ;
                    end
                end
            end
            S_DATA: begin
                if (timeout) begin
                    state_nx = S_IDLE;
                end else if (last_byte) begin
                    state_nx = misaligned ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (hold_ack) begin
                    state_nx = S_BUS;
                end
            end
            S_BUS: begin
                state_nx = S_RESP;
            end
            S_RESP: begin
                if (tx_fire && resp_left == 3'd1) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 2'd0;
            is_write   <= 1'b0;
            misaligned <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_q     <= 32'h0;
            resp_left  <= 3'd0;
            to_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt    <= 2'd0;
                    to_cnt <= '0;
                    if (rx_valid) begin
                        is_write   <= (rx_data == CMD_W);
                        misaligned <= 1'b0;
                        if (rx_data != CMD_W && rx_data != CMD_R) begin
                            resp_q    <= {RSP_Q, 24'h0};
                            resp_left <= 3'd1;
                        end
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rx_valid) begin
                        to_cnt <= '0;
                        cnt    <= cnt + 2'd1;
                        if (state == S_ADDR) begin
                            addr_q <= {addr_q[23:0], rx_data};
                            if (last_byte) begin
                                misaligned <= (rx_data[1:0] != 2'b00);
                                if (!is_write && rx_data[1:0] != 2'b00) begin
                                    resp_q    <= {RSP_E, 24'h0};
                                    resp_left <= 3'd1;
                                end
                            end
                        end else begin
                            wdata_q <= {wdata_q[23:0], rx_data};
                            if (last_byte && misaligned) begin
                                resp_q    <= {RSP_E, 24'h0};
                                resp_left <= 3'd1;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_BUS: begin
                    if (is_write) begin
                        resp_q    <= {RSP_K, 24'h0};
                        resp_left <= 3'd1;
                    end else begin
                        resp_q    <= bus_rdata;
                        resp_left <= 3'd4;
                    end
                end
                S_RESP: begin
                    // Response bytes leave MSB first from the top of resp_q.
                    if (tx_fire) begin
                        resp_q    <= {resp_q[23:0], 8'h00};
                        resp_left <= resp_left - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
